// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared FSM state type and pointer helper for the round-robin arbiter
package rr_arb_pkg;
  typedef enum logic {ST_IDLE, ST_OWN} rr_arb_state_t;
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin pick, first request at or after ptr (wrapping)
module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               vld,
  output logic [IDX_W-1:0]   idx
);
  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;
  assign rot = NUM_REQ'({req, req} >> ptr);
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
  end
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
  assign vld = |req;
endmodule

// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock: N-way round-robin arbiter that holds the grant across a transfer.
// Define RR_ARB_HOLD_LIMIT_EN to force release after MAX_HOLD granted cycles.
module rr_arbiter_lock
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int IDX_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_an,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld,
  output logic               hold_expired
);
  rr_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               vld_q, pick_vld, rel, force_rel;

  if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_param_chk
    $error("rr_arbiter_lock: NUM_REQ and MAX_HOLD must be >= 2");
  end

  rr_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Owner releases by dropping req or by flagging its final granted cycle
  assign rel = !req[idx_q] || last[idx_q];

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;
  assign force_rel = state_q == ST_OWN && cnt_q == CNT_W'(MAX_HOLD - 1);
  assign cnt_d     = (state_q == ST_OWN && !rel && !force_rel) ? cnt_q + 1'b1 : '0;
  assign exp_d     = force_rel && !rel;
  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  assign hold_expired = exp_q;
`else
  assign force_rel    = 1'b0;
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    if (state_q == ST_IDLE && pick_vld) begin
      state_d = ST_OWN;
      idx_d   = pick_idx;
      grant_d = NUM_REQ'(1) << pick_idx;
    end else if (state_q == ST_OWN && (rel || force_rel)) begin
      state_d = ST_IDLE;
      ptr_d   = IDX_W'(next_ptr(int'(idx_q), NUM_REQ));
      grant_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_an)
    if (!rst_an) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      vld_q   <= |grant_d;
    end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
endmodule
